// File: rtl/sprite_ram_responder.sv
// sprite_ram_responder: double-banked sprite attribute/coordinate RAM for the sprite datapath.
//   clk, rst_n          : rising-edge clock, async active-low reset
//   vblank              : vertical blank; its rising edge commits shadow -> active
//   rd_en, sprite_dp_RAM_addr -> sprite_RAM_dout, rd_valid : video read port, 1-cycle latency, active bank
//   cpu_wr_en, cpu_rd_en, cpu_addr, cpu_wdata -> cpu_rdata : CPU port, shadow bank, 1-cycle read latency
//   commit_done         : one-cycle pulse the cycle after a shadow-to-active copy
module sprite_ram_responder #(
  parameter logic [15:0] ATTR_BASE  = 16'h4FF0,
  parameter logic [15:0] COORD_BASE = 16'h5060
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vblank,
  input  logic        rd_en,
  input  logic [15:0] sprite_dp_RAM_addr,
  output logic [7:0]  sprite_RAM_dout,
  output logic        rd_valid,
  input  logic        cpu_wr_en,
  input  logic        cpu_rd_en,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        commit_done
);
  typedef enum logic {IDLE, ARMED} state_t;
  state_t state, state_nx;
  logic [7:0] shadow [32];
  logic [7:0] active [32];
  logic       vblank_q, dirty, vb_rise, commit, cpu_wr_hit;
  logic       rd_map, cpu_map;
  logic [4:0] rd_idx, cpu_idx;
  always_comb begin
    rd_map     = sprite_dp_RAM_addr[15:4] == ATTR_BASE[15:4] || sprite_dp_RAM_addr[15:4] == COORD_BASE[15:4];
    cpu_map    = cpu_addr[15:4] == ATTR_BASE[15:4] || cpu_addr[15:4] == COORD_BASE[15:4];
    rd_idx     = {sprite_dp_RAM_addr[15:4] == COORD_BASE[15:4], sprite_dp_RAM_addr[3:0]};
    cpu_idx    = {cpu_addr[15:4] == COORD_BASE[15:4], cpu_addr[3:0]};
    cpu_wr_hit = cpu_wr_en & cpu_map;
    vb_rise    = vblank & ~vblank_q;
    // Arming requires a sampled low vblank, so a held-high vblank commits at most once.
    commit     = (state == ARMED) & vb_rise & dirty;
    state_nx   = (state == IDLE) ? (vblank ? IDLE : ARMED) : (vb_rise ? IDLE : ARMED);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      sprite_RAM_dout <= '0;
      rd_valid        <= 1'b0;
      cpu_rdata       <= '0;
      commit_done     <= 1'b0;
      dirty           <= 1'b0;
      vblank_q        <= 1'b0;
    end else begin
      vblank_q        <= vblank;
      commit_done     <= commit;
      rd_valid        <= rd_en;
      // Non-blocking reads see pre-edge contents, so same-edge commits and writes are invisible here.
      sprite_RAM_dout <= (rd_en && rd_map) ? active[rd_idx] : 8'h00;
      if (cpu_rd_en) cpu_rdata <= cpu_map ? shadow[cpu_idx] : 8'h00;
      if (commit)
        for (int i = 0; i < 32; i++) active[i] <= shadow[i];
      if (cpu_wr_hit) shadow[cpu_idx] <= cpu_wdata;
      // A write landing on the commit edge missed the copy, so it keeps the bank dirty.
      dirty <= cpu_wr_hit | (dirty & ~commit);
    end
  end
endmodule

// File: tb/tb_sprite_ram_responder.sv
// tb_sprite_ram_responder: directed and randomized checks of sprite_ram_responder against a bank-level model.
module tb_sprite_ram_responder;
  logic        clk = 0, rst_n = 0, vblank = 0, rd_en = 0, cpu_wr_en = 0, cpu_rd_en = 0;
  logic [15:0] sprite_dp_RAM_addr = 0, cpu_addr = 0;
  logic [7:0]  cpu_wdata = 0;
  logic [7:0]  sprite_RAM_dout, cpu_rdata;
  logic        rd_valid, commit_done;
  int passed = 0, total = 0;
  logic [7:0] sh [32];
  logic [7:0] ac [32];
  bit m_dirty, m_armed, m_vbq, e_valid, e_done;
  logic [7:0] e_dout, e_crd;

  sprite_ram_responder dut (
    .clk(clk), .rst_n(rst_n), .vblank(vblank), .rd_en(rd_en),
    .sprite_dp_RAM_addr(sprite_dp_RAM_addr), .sprite_RAM_dout(sprite_RAM_dout),
    .rd_valid(rd_valid), .cpu_wr_en(cpu_wr_en), .cpu_rd_en(cpu_rd_en),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .commit_done(commit_done)
  );

  always #5 clk = ~clk;

  function automatic bit is_map(input logic [15:0] a);
    return (a >= 16'h4FF0 && a <= 16'h4FFF) || (a >= 16'h5060 && a <= 16'h506F);
  endfunction

  function automatic int ix(input logic [15:0] a);
    return (a >= 16'h5060 && a <= 16'h506F) ? 16 + int'(a) - 'h5060 : int'(a) - 'h4FF0;
  endfunction

  function automatic logic [15:0] addr_of(input int i);
    return i < 16 ? 16'(32'h4FF0 + i) : 16'(32'h5060 + i - 16);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      sh[i] = 0;
      ac[i] = 0;
    end
    m_dirty = 0; m_armed = 0; m_vbq = 0;
    e_dout = 0; e_crd = 0; e_valid = 0; e_done = 0;
  endtask

  // Drives one clock of stimulus, advances the model, and returns #1 after the edge.
  task automatic cyc(input bit vb, input bit rd, input logic [15:0] ra, input bit we,
                     input bit re, input logic [15:0] ca, input logic [7:0] wd);
    bit fire, com;
    vblank = vb; rd_en = rd; sprite_dp_RAM_addr = ra;
    cpu_wr_en = we; cpu_rd_en = re; cpu_addr = ca; cpu_wdata = wd;
    e_valid = rd;
    e_dout  = (rd && is_map(ra)) ? ac[ix(ra)] : 8'h00;
    if (re) e_crd = is_map(ca) ? sh[ix(ca)] : 8'h00;
    fire   = m_armed && vb && !m_vbq;
    com    = fire && m_dirty;
    e_done = com;
    if (com) ac = sh;
    if (we && is_map(ca)) begin
      sh[ix(ca)] = wd;
      m_dirty = 1;
    end else if (com) m_dirty = 0;
    if (fire) m_armed = 0;
    else if (!vb) m_armed = 1;
    m_vbq = vb;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit vb);
    cyc(vb, 0, 16'h0, 0, 0, 16'h0, 8'h00);
  endtask

  task automatic test_reset();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    cyc(0, 0, 16'h0, 1, 0, 16'h5060, 8'h77);
    cyc(0, 1, 16'h5060, 0, 1, 16'h5060, 8'h00);
    total++; if (cpu_rdata !== 8'h77) $display("FAIL reset_pre_cpu_rdata got=%h exp=%h", cpu_rdata, 8'h77); else passed++;
    #2 rst_n = 0;
    #1;
    total++; if (cpu_rdata !== 8'h00) $display("FAIL reset_async_cpu_rdata got=%h exp=00", cpu_rdata); else passed++;
    total++; if (rd_valid !== 1'b0) $display("FAIL reset_async_rd_valid got=%b exp=0", rd_valid); else passed++;
    total++; if (commit_done !== 1'b0 || sprite_RAM_dout !== 8'h00) $display("FAIL reset_async_outs got=%b/%h exp=0/00", commit_done, sprite_RAM_dout); else passed++;
    model_reset();
    @(negedge clk) rst_n = 1;
    cyc(1, 0, 16'h0, 0, 0, 16'h0, 8'h00);
    total++; if (commit_done !== 1'b0) $display("FAIL reset_no_commit got=%b exp=0", commit_done); else passed++;
    cyc(1, 1, 16'h5060, 0, 1, 16'h5060, 8'h00);
    total++; if (sprite_RAM_dout !== 8'h00 || rd_valid !== 1'b1) $display("FAIL reset_read_5060 got=%h/%b exp=00/1", sprite_RAM_dout, rd_valid); else passed++;
    total++; if (cpu_rdata !== 8'h00) $display("FAIL reset_shadow_cleared got=%h exp=00", cpu_rdata); else passed++;
  endtask

  task automatic test_shadow_commit();
    cyc(0, 0, 16'h0, 1, 0, 16'h4FF3, 8'hA5);
    cyc(0, 1, 16'h4FF3, 0, 0, 16'h0, 8'h00);
    total++; if (sprite_RAM_dout !== 8'h00) $display("FAIL shadow_isolated got=%h exp=00", sprite_RAM_dout); else passed++;
    idle(1);
    total++; if (commit_done !== 1'b1) $display("FAIL commit_pulse got=%b exp=1", commit_done); else passed++;
    cyc(1, 1, 16'h4FF3, 0, 0, 16'h0, 8'h00);
    total++; if (commit_done !== 1'b0) $display("FAIL commit_pulse_width got=%b exp=0", commit_done); else passed++;
    total++; if (sprite_RAM_dout !== 8'hA5) $display("FAIL committed_read got=%h exp=a5", sprite_RAM_dout); else passed++;
  endtask

  task automatic test_unmapped_clean();
    idle(0);
    cyc(0, 0, 16'h0, 1, 0, 16'h5070, 8'hFF);
    cyc(0, 1, 16'h4FEF, 0, 1, 16'h5070, 8'h00);
    total++; if (sprite_RAM_dout !== 8'h00 || rd_valid !== 1'b1) $display("FAIL unmapped_video got=%h/%b exp=00/1", sprite_RAM_dout, rd_valid); else passed++;
    total++; if (cpu_rdata !== 8'h00) $display("FAIL unmapped_cpu got=%h exp=00", cpu_rdata); else passed++;
    idle(1);
    total++; if (commit_done !== 1'b0) $display("FAIL clean_no_commit got=%b exp=0", commit_done); else passed++;
  endtask

  task automatic test_collision();
    idle(0);
    cyc(0, 0, 16'h0, 1, 0, 16'h4FF5, 8'h5A);
    cyc(1, 1, 16'h5061, 1, 1, 16'h5061, 8'h3C);
    total++; if (sprite_RAM_dout !== 8'h00) $display("FAIL collide_video_old got=%h exp=00", sprite_RAM_dout); else passed++;
    total++; if (cpu_rdata !== 8'h00) $display("FAIL collide_cpu_old got=%h exp=00", cpu_rdata); else passed++;
    total++; if (commit_done !== 1'b1) $display("FAIL collide_commit got=%b exp=1", commit_done); else passed++;
    cyc(1, 1, 16'h4FF5, 0, 0, 16'h0, 8'h00);
    total++; if (sprite_RAM_dout !== 8'h5A) $display("FAIL collide_other_byte got=%h exp=5a", sprite_RAM_dout); else passed++;
    cyc(1, 1, 16'h5061, 0, 0, 16'h0, 8'h00);
    total++; if (sprite_RAM_dout !== 8'h00) $display("FAIL collide_not_yet got=%h exp=00", sprite_RAM_dout); else passed++;
    idle(0);
    idle(1);
    total++; if (commit_done !== 1'b1) $display("FAIL collide_dirty_kept got=%b exp=1", commit_done); else passed++;
    cyc(1, 1, 16'h5061, 0, 0, 16'h0, 8'h00);
    total++; if (sprite_RAM_dout !== 8'h3C) $display("FAIL collide_late_visible got=%h exp=3c", sprite_RAM_dout); else passed++;
  endtask

  task automatic test_vblank_held();
    int pulses = 0;
    cyc(1, 0, 16'h0, 1, 0, 16'h4FF0, 8'h11);
    repeat (100) begin
      idle(1);
      if (commit_done) pulses++;
    end
    total++; if (pulses !== 0) $display("FAIL held_extra_commits got=%0d exp=0", pulses); else passed++;
    cyc(1, 1, 16'h4FF0, 0, 0, 16'h0, 8'h00);
    total++; if (sprite_RAM_dout !== 8'h00) $display("FAIL held_not_visible got=%h exp=00", sprite_RAM_dout); else passed++;
    idle(0);
    idle(1);
    total++; if (commit_done !== 1'b1) $display("FAIL rearm_commit got=%b exp=1", commit_done); else passed++;
    cyc(1, 1, 16'h4FF0, 0, 0, 16'h0, 8'h00);
    total++; if (sprite_RAM_dout !== 8'h11) $display("FAIL rearm_visible got=%h exp=11", sprite_RAM_dout); else passed++;
  endtask

  task automatic test_stream();
    int bad = 0;
    idle(0);
    for (int i = 0; i < 32; i++) cyc(0, 0, 16'h0, 1, 0, addr_of(i), 8'(i + 1));
    idle(1);
    total++; if (commit_done !== 1'b1) $display("FAIL stream_commit got=%b exp=1", commit_done); else passed++;
    for (int i = 0; i < 32; i++) begin
      cyc(1, 1, addr_of(i), 0, 0, 16'h0, 8'h00);
      total++;
      if (sprite_RAM_dout !== 8'(i + 1) || rd_valid !== 1'b1) begin
        $display("FAIL stream_byte_%0d got=%h/%b exp=%h/1", i, sprite_RAM_dout, rd_valid, 8'(i + 1));
        bad++;
      end else passed++;
    end
    idle(1);
    total++; if (rd_valid !== 1'b0 || sprite_RAM_dout !== 8'h00) $display("FAIL stream_end got=%b/%h exp=0/00", rd_valid, sprite_RAM_dout); else passed++;
  endtask

  function automatic logic [15:0] rand_addr();
    logic [15:0] edges [4] = '{16'h4FEF, 16'h5000, 16'h505F, 16'h5070};
    case ($urandom_range(0, 3))
      0: return 16'(32'h4FF0 + $urandom_range(0, 15));
      1: return 16'(32'h5060 + $urandom_range(0, 15));
      2: return edges[$urandom_range(0, 3)];
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic test_random();
    bit vb = 1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 5) == 0) vb = ~vb;
      cyc(vb, 1'($urandom), rand_addr(), $urandom_range(0, 2) == 0, 1'($urandom), rand_addr(), 8'($urandom));
      total++; if (sprite_RAM_dout !== e_dout) $display("FAIL rand_dout n=%0d got=%h exp=%h", n, sprite_RAM_dout, e_dout); else passed++;
      total++; if (rd_valid !== e_valid) $display("FAIL rand_valid n=%0d got=%b exp=%b", n, rd_valid, e_valid); else passed++;
      total++; if (cpu_rdata !== e_crd) $display("FAIL rand_cpu_rdata n=%0d got=%h exp=%h", n, cpu_rdata, e_crd); else passed++;
      total++; if (commit_done !== e_done) $display("FAIL rand_commit n=%0d got=%b exp=%b", n, commit_done, e_done); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_shadow_commit();
    test_unmapped_clean();
    test_collision();
    test_vblank_held();
    test_stream();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/sprite_ram_responder.md
# sprite_ram_responder

Responder side of the sprite datapath's RAM read interface: holds the 16 sprite attribute bytes and 16 sprite coordinate bytes, and answers `rd_en`/address requests with one-cycle-latency data. CPU writes go to a shadow bank. The shadow bank is committed to the active (video-visible) bank at the start of each vblank, so the sprite datapath never sees a half-updated frame. Sits between the CPU bus decode and `sprite_datapath`, replacing the bare RAM model on that interface.

## Interface
Parameters:
- `ATTR_BASE`, 16'h4FF0, base of attribute window (16 bytes: code/flip, colour per sprite)
- `COORD_BASE`, 16'h5060, base of coordinate window (16 bytes: x/y per sprite)

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `vblank`  in  1  vertical blank from video timing
- `rd_en`  in  1  read strobe from sprite datapath
- `sprite_dp_RAM_addr`  in  16  read address from sprite datapath
- `sprite_RAM_dout`  out  8  read data; connects to datapath `sprite_RAM_din`
- `rd_valid`  out  1  registered `rd_en`; high in the cycle `sprite_RAM_dout` is valid
- `cpu_wr_en`  in  1  CPU write strobe
- `cpu_rd_en`  in  1  CPU read strobe
- `cpu_addr`  in  16  CPU address
- `cpu_wdata`  in  8  CPU write data
- `cpu_rdata`  out  8  CPU read data (shadow bank), one-cycle latency
- `commit_done`  out  1  one-cycle pulse after a shadow-to-active copy

## Operation
- **Storage:** two 32x8 banks, `shadow` and `active`.
  - Index = {window_sel, addr[3:0]}; window_sel = 0 for the attribute window, 1 for the coordinate window.
  - An address is mapped iff addr[15:4] == ATTR_BASE[15:4] or addr[15:4] == COORD_BASE[15:4].
- **Video read:** on an edge with `rd_en`=1:
  - `sprite_RAM_dout` <= active[idx] if mapped, else 8'h00.
  - `rd_valid` <= 1.
  - With `rd_en`=0: `rd_valid` <= 0 and `sprite_RAM_dout` <= 8'h00, matching the existing datapath bench convention.
- **CPU write:** `cpu_wr_en`=1 to a mapped address sets shadow[idx] <= `cpu_wdata` and sets `dirty`. Unmapped writes are ignored and do not set `dirty`.
- **CPU read:** `cpu_rd_en`=1 gives `cpu_rdata` <= shadow[idx], or 8'h00 if unmapped. `cpu_rdata` holds its value when `cpu_rd_en`=0.
- **vblank edge detect:** `vblank_q` <= `vblank` every cycle. `vb_rise` = `vblank` & ~`vblank_q`.
- **Commit FSM** (states IDLE, ARMED):
  - IDLE -> ARMED when `vblank`=0 is sampled.
  - ARMED with `vb_rise`: if `dirty`, all 32 active bytes <= shadow in that single edge, and `commit_done` <= 1 on the next cycle. Then go to IDLE.
  - ARMED with `vb_rise` and `dirty`=0: no copy, no pulse; go to IDLE.
- **dirty:** cleared on a commit edge, unless a mapped CPU write occurs on that same edge, in which case `dirty` stays 1.

## Timing
- **Reset (async, `rst_n`=0):**
  - Both banks = 0.
  - `sprite_RAM_dout`=0, `rd_valid`=0, `cpu_rdata`=0, `commit_done`=0.
  - `dirty`=0, `vblank_q`=0, FSM=IDLE.
- **Reset mid-frame:** all of the above take effect immediately; any pending commit is lost.
- **Read latency:** exactly 1 cycle for both ports. Back-to-back reads every cycle are supported, with no stall.
- **Commit vs video read, same edge:** a read sampled on the commit edge returns the pre-commit active value. A read on the following edge returns the new value.
- **Commit vs CPU write, same edge:** the copy uses pre-edge shadow contents. The new byte lands in shadow only and is visible to video after the next commit.
- **CPU read/write, same address, same edge:** `cpu_rdata` returns the old value.
- **vblank held high:** only one commit per vblank. A new commit requires `vblank`=0 to be sampled first (re-arm).
- **vblank high out of reset:** FSM is IDLE, so no commit occurs until a 0->1 transition.
- **`commit_done`:** exactly one cycle wide, asserted the cycle after the commit edge.

## Test plan
- **Reset defaults:** assert `rst_n`=0 mid-cycle, then read active addr 16'h5060 via `rd_en` -> `sprite_RAM_dout`=8'h00 one cycle later, `rd_valid`=1.
- **Shadow isolation, then commit:** CPU writes 8'hA5 to 16'h4FF3 with `vblank`=0.
  - Video read of 16'h4FF3 -> 8'h00.
  - Raise `vblank` -> `commit_done` pulses 1 cycle.
  - Next video read of 16'h4FF3 -> 8'hA5.
- **Unmapped and clean commit:** write to 16'h5070, then read 16'h4FEF via video -> 8'h00. A vblank rise with `dirty`=0 -> no `commit_done`.
- **Same-edge collisions:** CPU writes 8'h3C to 16'h5061 on the commit edge, with a video read of 16'h5061 on the same edge.
  - Video read returns pre-commit 8'h00.
  - Later reads return 8'h00 until the next vblank, then 8'h3C.
  - `dirty` stays 1 after the commit edge.
- **vblank held, then re-arm:** keep `vblank`=1 for 100 cycles after a commit and write 8'h11 to 16'h4FF0 -> no second commit. Drop `vblank` for 1 cycle and raise it -> commit, and active 16'h4FF0=8'h11.
- **Streaming read:** `rd_en` high for 32 consecutive cycles over all mapped addresses after committing a known pattern (byte i = i+1) -> data matches with exactly 1-cycle lag and `rd_valid` high throughout.
